// File: rtl/arithmetic_shift_divider_serial_if.sv
// arithmetic_shift_divider_serial_if: ready/valid request and result bundle for the serial shift divider.
interface arithmetic_shift_divider_serial_if #(parameter int N = 8);
    localparam int SW = $clog2(N);
    logic                in_valid;
    logic                in_ready;
    logic signed [N-1:0] in_data;
    logic [SW-1:0]       in_shift;
    logic                in_mode;
    logic                out_valid;
    logic                out_ready;
    logic signed [N-1:0] out_data;
    logic                out_inexact;
    modport master (
        output in_valid, in_data, in_shift, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_inexact
    );
    modport slave (
        input  in_valid, in_data, in_shift, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_inexact
    );
endinterface

// File: rtl/arithmetic_shift_divider_serial.sv
// arithmetic_shift_divider_serial: multi-cycle signed divide by 2**s, floor or toward-zero, with inexact flag.
module arithmetic_shift_divider_serial #(
    parameter int N    = 8,
    parameter int STEP = 1
) (
    input logic clk,
    input logic rst_n,
    arithmetic_shift_divider_serial_if.slave bus
);
    localparam int SW = $clog2(N);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t              r_state, w_state_nxt;
    logic signed [N-1:0] r_w, w_w_nxt, w_load;
    logic [SW-1:0]       r_rem, w_rem_nxt, w_eff, w_k;
    logic                r_inexact, w_inexact_nxt;
    logic [SW:0]         w_sh_ext;
    logic [N-1:0]        w_mask;
    assign w_sh_ext = {1'b0, bus.in_shift};
    assign w_eff    = (w_sh_ext > (SW+1)'(N-1)) ? SW'(N-1) : bus.in_shift;
    assign w_mask   = ~({N{1'b1}} << w_eff);
    // Biasing negatives by 2**e-1 turns the floor shift into truncation toward zero.
    assign w_load   = (bus.in_mode && bus.in_data[N-1]) ? bus.in_data + w_mask : bus.in_data;
    assign w_k      = (r_rem > SW'(STEP)) ? SW'(STEP) : r_rem;
    always_comb begin
        w_state_nxt   = r_state;
        w_w_nxt       = r_w;
        w_rem_nxt     = r_rem;
        w_inexact_nxt = r_inexact;
        unique case (r_state)
            IDLE: if (bus.in_valid) begin
                w_w_nxt       = w_load;
                w_rem_nxt     = w_eff;
                w_inexact_nxt = |(bus.in_data & w_mask);
                w_state_nxt   = (w_eff != '0) ? SHIFT : DONE;
            end
            SHIFT: begin
                w_w_nxt     = r_w >>> w_k;
                w_rem_nxt   = r_rem - w_k;
                w_state_nxt = (r_rem == w_k) ? DONE : SHIFT;
            end
            DONE:    w_state_nxt = bus.out_ready ? IDLE : DONE;
            default: w_state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_w       <= '0;
            r_rem     <= '0;
            r_inexact <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_w       <= w_w_nxt;
            r_rem     <= w_rem_nxt;
            r_inexact <= w_inexact_nxt;
        end
    end
    assign bus.in_ready    = (r_state == IDLE);
    assign bus.out_valid   = (r_state == DONE);
    assign bus.out_data    = r_w;
    assign bus.out_inexact = r_inexact;
endmodule

// File: tb/tb_arithmetic_shift_divider_serial.sv
// tb_arithmetic_shift_divider_serial: directed and randomized checks against an integer-arithmetic model.
module tb_arithmetic_shift_divider_serial;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;
    logic        v_in_valid[5], v_in_mode[5], v_out_ready[5];
    logic [11:0] v_in_data[5];
    logic [3:0]  v_in_shift[5];
    logic        v_in_ready[5], v_out_valid[5], v_out_inexact[5];
    logic [11:0] v_out_data[5];
    int total = 0;
    int bad = 0;

    function automatic int n_of(input int i);
        return i < 3 ? 8 : 12;
    endfunction

    function automatic int step_of(input int i);
        return i == 0 ? 2 : (i % 2 == 1 ? 1 : 3);
    endfunction

    for (genvar g = 0; g < 5; g++) begin : g_dut
        localparam int NW = g < 3 ? 8 : 12;
        localparam int ST = g == 0 ? 2 : (g % 2 == 1 ? 1 : 3);
        localparam int SW = $clog2(NW);
        arithmetic_shift_divider_serial_if #(.N(NW)) bus ();
        assign bus.in_valid      = v_in_valid[g];
        assign bus.in_data       = v_in_data[g][NW-1:0];
        assign bus.in_shift      = v_in_shift[g][SW-1:0];
        assign bus.in_mode       = v_in_mode[g];
        assign bus.out_ready     = v_out_ready[g];
        assign v_in_ready[g]     = bus.in_ready;
        assign v_out_valid[g]    = bus.out_valid;
        assign v_out_data[g]     = 12'(bus.out_data);
        assign v_out_inexact[g]  = bus.out_inexact;
        arithmetic_shift_divider_serial #(.N(NW), .STEP(ST)) dut (
            .clk(clk), .rst_n(rst_n), .bus(bus.slave)
        );
    end

    function automatic void model(input int n, input logic [11:0] d, input logic [3:0] s, input logic m,
                                  output int q, output logic x, output int e);
        int dv, dvs;
        dv = int'(d) & ((1 << n) - 1);
        if (dv >= (1 << (n - 1))) dv -= (1 << n);
        e = int'(s) > n - 1 ? n - 1 : int'(s);
        dvs = 1 << e;
        q = dv / dvs;
        if (!m && dv < 0 && dv % dvs != 0) q -= 1;
        x = (dv % dvs) != 0;
    endfunction

    task automatic run_op(input int idx, input logic [11:0] d, input logic [3:0] s, input logic m,
                          input bit rnd_ready, output int q, output logic x, output int lat);
        int guard = 0;
        while (!v_in_ready[idx] && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        v_in_valid[idx] = 1'b1; v_in_data[idx] = d; v_in_shift[idx] = s; v_in_mode[idx] = m;
        v_out_ready[idx] = 1'b0;
        @(posedge clk); #1;
        lat = 1;
        v_in_valid[idx] = 1'b0; v_in_data[idx] = 12'($urandom); v_in_shift[idx] = 4'($urandom);
        v_in_mode[idx] = 1'($urandom);
        while (!v_out_valid[idx] && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        q = int'($signed(v_out_data[idx]));
        x = v_out_inexact[idx];
        if (rnd_ready) repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        v_out_ready[idx] = 1'b1;
        @(posedge clk); #1;
        v_out_ready[idx] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total++; if (v_in_ready[0] !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", v_in_ready[0]); end
        total++; if (v_out_valid[0] !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", v_out_valid[0]); end
        total++; if (v_out_data[0] !== 12'h000) begin bad++; $display("FAIL reset_out_data got=%h exp=000", v_out_data[0]); end
        total++; if (v_out_inexact[0] !== 1'b0) begin bad++; $display("FAIL reset_out_inexact got=%b exp=0", v_out_inexact[0]); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        int td[8] = '{-100, -100, 96, 96, -7, -1, -1, -128};
        int ts[8] = '{3, 3, 5, 5, 0, 7, 7, 7};
        int tm[8] = '{0, 1, 0, 1, 1, 0, 1, 1};
        int tq[8] = '{-13, -12, 3, 3, -7, -1, 0, -1};
        int tx[8] = '{1, 1, 0, 0, 0, 1, 1, 0};
        int tl[8] = '{3, 3, 4, 4, 1, 5, 5, 5};
        int q, lat;
        logic x;
        for (int i = 0; i < 8; i++) begin
            run_op(0, 12'(td[i]), 4'(ts[i]), 1'(tm[i]), 1'b0, q, x, lat);
            total++; if (q !== tq[i]) begin bad++; $display("FAIL directed_data[%0d] got=%0d exp=%0d", i, q, tq[i]); end
            total++; if (x !== 1'(tx[i])) begin bad++; $display("FAIL directed_inexact[%0d] got=%b exp=%0d", i, x, tx[i]); end
            total++; if (lat !== tl[i]) begin bad++; $display("FAIL directed_latency[%0d] got=%0d exp=%0d", i, lat, tl[i]); end
        end
    endtask

    task automatic test_backpressure();
        int guard = 0;
        v_in_valid[0] = 1'b1; v_in_data[0] = 12'd50; v_in_shift[0] = 4'd2; v_in_mode[0] = 1'b0;
        v_out_ready[0] = 1'b0;
        @(posedge clk); #1;
        v_in_valid[0] = 1'b0;
        while (!v_out_valid[0] && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        for (int i = 0; i < 5; i++) begin
            v_in_valid[0] = 1'b1; v_in_data[0] = 12'($urandom); v_in_shift[0] = 4'($urandom_range(0, 7));
            @(posedge clk); #1;
            total++; if (v_out_valid[0] !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got=%b exp=1", i, v_out_valid[0]); end
            total++; if (v_out_data[0] !== 12'd12) begin bad++; $display("FAIL bp_data[%0d] got=%0d exp=12", i, v_out_data[0]); end
            total++; if (v_out_inexact[0] !== 1'b1) begin bad++; $display("FAIL bp_inexact[%0d] got=%b exp=1", i, v_out_inexact[0]); end
            total++; if (v_in_ready[0] !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, v_in_ready[0]); end
        end
        v_in_valid[0] = 1'b0; v_out_ready[0] = 1'b1;
        @(posedge clk); #1;
        total++; if (v_in_ready[0] !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", v_in_ready[0]); end
        total++; if (v_out_valid[0] !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%b exp=0", v_out_valid[0]); end
        v_out_ready[0] = 1'b0;
        @(posedge clk); #1;
        total++; if (v_in_ready[0] !== 1'b1) begin bad++; $display("FAIL bp_nothing_latched got=%b exp=1", v_in_ready[0]); end
    endtask

    task automatic test_reset_mid_shift();
        int q, lat;
        logic x;
        logic stale = 1'b0;
        v_in_valid[0] = 1'b1; v_in_data[0] = 12'hF9C; v_in_shift[0] = 4'd7; v_in_mode[0] = 1'b0;
        @(posedge clk); #1;
        v_in_valid[0] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        total++; if (v_in_ready[0] !== 1'b1) begin bad++; $display("FAIL midrst_in_ready got=%b exp=1", v_in_ready[0]); end
        total++; if (v_out_valid[0] !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%b exp=0", v_out_valid[0]); end
        total++; if (v_out_data[0] !== 12'h000) begin bad++; $display("FAIL midrst_out_data got=%h exp=000", v_out_data[0]); end
        total++; if (v_out_inexact[0] !== 1'b0) begin bad++; $display("FAIL midrst_out_inexact got=%b exp=0", v_out_inexact[0]); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (8) begin
            @(posedge clk); #1;
            if (v_out_valid[0] !== 1'b0) stale = 1'b1;
        end
        total++; if (stale !== 1'b0) begin bad++; $display("FAIL midrst_stale_valid got=%b exp=0", stale); end
        run_op(0, 12'd77, 4'd3, 1'b1, 1'b0, q, x, lat);
        total++; if (q !== 9) begin bad++; $display("FAIL midrst_next_data got=%0d exp=9", q); end
        total++; if (x !== 1'b1) begin bad++; $display("FAIL midrst_next_inexact got=%b exp=1", x); end
        total++; if (lat !== 3) begin bad++; $display("FAIL midrst_next_latency got=%0d exp=3", lat); end
    endtask

    task automatic test_random();
        int idx, n, q, lat, eq, e, el;
        logic x, ex, m;
        logic [11:0] d;
        logic [3:0] s;
        for (int i = 0; i < 1000; i++) begin
            idx = 1 + i % 4;
            n = n_of(idx);
            d = 12'($urandom);
            s = 4'($urandom_range(0, n == 8 ? 7 : 15));
            m = 1'($urandom);
            run_op(idx, d, s, m, 1'b1, q, x, lat);
            model(n, d, s, m, eq, ex, e);
            el = 1 + (e + step_of(idx) - 1) / step_of(idx);
            total++; if (q !== eq) begin bad++; $display("FAIL rnd_data[%0d] n=%0d d=%h s=%0d m=%b got=%0d exp=%0d", i, n, d, s, m, q, eq); end
            total++; if (x !== ex) begin bad++; $display("FAIL rnd_inexact[%0d] n=%0d d=%h s=%0d got=%b exp=%b", i, n, d, s, x, ex); end
            total++; if (lat !== el) begin bad++; $display("FAIL rnd_latency[%0d] n=%0d s=%0d got=%0d exp=%0d", i, n, s, lat, el); end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 5; i++) begin
            v_in_valid[i] = 1'b0; v_in_mode[i] = 1'b0; v_out_ready[i] = 1'b0;
            v_in_data[i] = '0; v_in_shift[i] = '0;
        end
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_shift();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
